// File: rtl/hdr_ctrl_engine_if.sv
// Request, completion, enable and status signals between the HDR control
// engine and the host/sub-blocks around it.
interface hdr_ctrl_engine_if;
  logic       i_start;
  logic       i_stop;
  logic       i_cmd_is_ccc;
  logic       i_ENTHDR_done;
  logic       i_tx_done;
  logic       i_NT_done;
  logic       i_CCC_done;
  logic       i_restart_done;
  logic       i_exit_done;
  logic       i_xfer_err;

  logic       o_ENTHDR_en;
  logic       o_tx_en;
  logic       o_NT_en;
  logic       o_CCC_en;
  logic       o_rstpat_en;
  logic       o_exitpat_en;
  logic [3:0] o_tx_mode;
  logic [1:0] o_muxes;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  // Host / sub-block side: issues requests and completion pulses.
  modport master (
    output i_start, i_stop, i_cmd_is_ccc,
    output i_ENTHDR_done, i_tx_done, i_NT_done, i_CCC_done,
    output i_restart_done, i_exit_done, i_xfer_err,
    input  o_ENTHDR_en, o_tx_en, o_NT_en, o_CCC_en, o_rstpat_en, o_exitpat_en,
    input  o_tx_mode, o_muxes, o_busy, o_done, o_error
  );

  // Engine side.
  modport slave (
    input  i_start, i_stop, i_cmd_is_ccc,
    input  i_ENTHDR_done, i_tx_done, i_NT_done, i_CCC_done,
    input  i_restart_done, i_exit_done, i_xfer_err,
    output o_ENTHDR_en, o_tx_en, o_NT_en, o_CCC_en, o_rstpat_en, o_exitpat_en,
    output o_tx_mode, o_muxes, o_busy, o_done, o_error
  );
endinterface

// File: rtl/hdr_ctrl_engine.sv
// HDR mode sequencer: enters HDR, sends the command word, hands the bus to
// the DDR or CCC handler, supports restarts and exits, and aborts any waiting
// state that exceeds TIMEOUT_CYCLES.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE_SDR    | not in HDR mode, waiting for i_start
// ENTHDR      | ENTHDR pattern generator running
// CMD_TX      | command word being transmitted
// DDR_NT      | DDR normal transfer owns the bus
// CCC_HANDLER | CCC handler owns the bus
// IDLE_HDR    | in HDR mode between transfers
// RESTART     | HDR restart pattern being sent
// EXIT        | HDR exit pattern being sent (no timeout)
module hdr_ctrl_engine #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         i_sys_clk,
  input  logic         i_sys_rst,
  hdr_ctrl_engine_if.slave bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE_SDR, ENTHDR, CMD_TX, DDR_NT, CCC_HANDLER, IDLE_HDR, RESTART, EXIT
  } state_t;

  state_t          state, nxt;
  logic            ccc_flag;
  logic [CW-1:0]   cnt;
  logic            done_q, error_q;
  logic            timed, set_done, set_err, latch_ccc;

  // Next-state decision; a done pulse always outranks the timeout.
  always_comb begin
    nxt       = state;
    set_done  = 1'b0;
    set_err   = 1'b0;
    latch_ccc = 1'b0;
    timed     = 1'b0;
    case (state)
      IDLE_SDR: begin
        if (bus.i_start) begin
          nxt       = ENTHDR;
          latch_ccc = 1'b1;
        end
      end
      ENTHDR: begin
        timed = 1'b1;
        if (bus.i_ENTHDR_done) nxt = CMD_TX;
      end
      CMD_TX: begin
        timed = 1'b1;
        if (bus.i_tx_done) nxt = ccc_flag ? CCC_HANDLER : DDR_NT;
      end
      DDR_NT: begin
        timed = 1'b1;
        if (bus.i_NT_done) begin
          nxt      = bus.i_xfer_err ? EXIT : IDLE_HDR;
          set_err  = bus.i_xfer_err;
          set_done = ~bus.i_xfer_err;
        end
      end
      CCC_HANDLER: begin
        timed = 1'b1;
        if (bus.i_CCC_done) begin
          nxt      = bus.i_xfer_err ? EXIT : IDLE_HDR;
          set_err  = bus.i_xfer_err;
          set_done = ~bus.i_xfer_err;
        end
      end
      IDLE_HDR: begin
        if (bus.i_stop) begin
          nxt = EXIT;
        end else if (bus.i_start) begin
          nxt       = RESTART;
          latch_ccc = 1'b1;
        end
      end
      RESTART: begin
        timed = 1'b1;
        if (bus.i_restart_done) nxt = CMD_TX;
      end
      EXIT: begin
        if (bus.i_exit_done) nxt = IDLE_SDR;
      end
      default: nxt = IDLE_SDR;
    endcase
    // Every timed state leaves on its own done pulse, so an unchanged
    // next state here means the done input was low.
    if (timed && (cnt == TC) && (nxt == state)) begin
      nxt     = EXIT;
      set_err = 1'b1;
    end
  end

  // State, command-type flag, timeout counter and status pulses.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state    <= IDLE_SDR;
      ccc_flag <= 1'b0;
      cnt      <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state   <= nxt;
      done_q  <= set_done;
      error_q <= set_err;
      if (latch_ccc) ccc_flag <= bus.i_cmd_is_ccc;
      if ((nxt != state) || !timed) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
    end
  end

  // Enables, mux select and mode are decoded from the current state only.
  always_comb begin
    bus.o_ENTHDR_en  = (state == ENTHDR);
    bus.o_tx_en      = (state == CMD_TX);
    bus.o_NT_en      = (state == DDR_NT);
    bus.o_CCC_en     = (state == CCC_HANDLER);
    bus.o_rstpat_en  = (state == RESTART);
    bus.o_exitpat_en = (state == EXIT);
    bus.o_tx_mode    = (state == CMD_TX) ? 4'b0001 : 4'b0000;
    bus.o_busy       = (state != IDLE_SDR);
    case (state)
      DDR_NT:      bus.o_muxes = 2'b01;
      CCC_HANDLER: bus.o_muxes = 2'b10;
      default:     bus.o_muxes = 2'b00;
    endcase
  end

  assign bus.o_done  = done_q;
  assign bus.o_error = error_q;

endmodule
